// File: rtl/branch_predict_unit_if.sv
// Fetch lookup, execute resolution and statistics signals of the branch predict unit.
// master = fetch/execute pipeline side, slave = branch_predict_unit.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             ex_valid;
  logic             branchOP;
  logic             jump;
  logic [2:0]       func;
  logic             BrEQ;
  logic             BrLT;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             PCsel;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output if_pc, ex_valid, branchOP, jump, func, BrEQ, BrLT,
           ex_pc, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, PCsel, mispredict, redirect_pc,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, ex_valid, branchOP, jump, func, BrEQ, BrLT,
           ex_pc, ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, PCsel, mispredict, redirect_pc,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch/jump resolution, direct-mapped BTB with 2-bit counters, mispredict redirect and statistics.
// Zero-latency lookup and resolution; table/counters update on the clock edge; no backpressure.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [XLEN-1:0]    btb_target [ENTRIES];
  logic [1:0]         btb_ctr    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             is_branch, cond_taken, resolved, taken;
  logic [1:0]       ctr_next;
  logic [CNT_W-1:0] branch_q, mispred_q;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign if_tag = bus.if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign ex_tag = bus.ex_pc[XLEN-1:IDX_W+2];
  assign if_hit = !rst && btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);

  assign bus.pred_taken  = if_hit & btb_ctr[if_idx][1];
  assign bus.pred_target = if_hit ? btb_target[if_idx] : bus.if_pc + XLEN'(4);

  // funct3 010/011 are not branch encodings: never taken, never counted
  always_comb begin
    is_branch  = 1'b0;
    cond_taken = 1'b0;
    case (bus.func)
      3'b000:         begin is_branch = 1'b1; cond_taken = bus.BrEQ;  end
      3'b001:         begin is_branch = 1'b1; cond_taken = !bus.BrEQ; end
      3'b100, 3'b110: begin is_branch = 1'b1; cond_taken = bus.BrLT;  end
      3'b101, 3'b111: begin is_branch = 1'b1; cond_taken = !bus.BrLT; end
      default:        ;
    endcase
  end

  assign resolved = bus.ex_valid & (bus.jump | (bus.branchOP & is_branch));
  assign taken    = bus.ex_valid & (bus.jump | (bus.branchOP & cond_taken));

  assign bus.PCsel       = taken;
  assign bus.mispredict  = resolved & ((taken != bus.ex_pred_taken) |
                                       (taken & (bus.ex_target != bus.ex_pred_target)));
  assign bus.redirect_pc = taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
  assign bus.branch_cnt  = branch_q;
  assign bus.mispred_cnt = mispred_q;

  always_comb begin
    ctr_next = 2'b00;
    if (bus.jump)
      ctr_next = 2'b11;
    else if (!ex_hit)
      ctr_next = 2'b10;
    else if (taken)
      ctr_next = (btb_ctr[ex_idx] == 2'b11) ? 2'b11 : btb_ctr[ex_idx] + 2'd1;
    else
      ctr_next = (btb_ctr[ex_idx] == 2'b00) ? 2'b00 : btb_ctr[ex_idx] - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (resolved && (ex_hit || taken)) begin
      // a taken miss overwrites whatever lives at this index
      btb_valid[ex_idx] <= 1'b1;
      btb_tag[ex_idx]   <= ex_tag;
      btb_ctr[ex_idx]   <= ctr_next;
      if (taken)
        btb_target[ex_idx] <= bus.ex_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      if (resolved && branch_q != '1)
        branch_q <= branch_q + CNT_W'(1);
      if (bus.mispredict && mispred_q != '1)
        mispred_q <= mispred_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: funct3 table sweep plus hand-written BTB sequences.
module tb_branch_predict_unit;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // mask bit {BrEQ,BrLT} = expected PCsel for that comparator combination
  typedef struct packed {
    logic [2:0] func;
    logic [3:0] mask;
  } vec_t;

  typedef struct packed {
    logic        chk_res;
    logic        pcsel;
    logic        mis;
    logic [31:0] redir;
    logic        chk_pred;
    logic        pt;
    logic [31:0] ptgt;
  } exp_t;

  vec_t tbl [8];
  exp_t sb [$];
  int   tests  = 0;
  int   failed = 0;
  logic [1:0] cc;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lk(input logic [31:0] pc);
    bus.if_pc = pc;
  endtask

  task automatic ex(input logic v, input logic bop, input logic j, input logic [2:0] f,
                    input logic eq, input logic lt, input logic [31:0] pc, input logic [31:0] tgt,
                    input logic ppt, input logic [31:0] ppc);
    bus.ex_valid       = v;
    bus.branchOP       = bop;
    bus.jump           = j;
    bus.func           = f;
    bus.BrEQ           = eq;
    bus.BrLT           = lt;
    bus.ex_pc          = pc;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ppt;
    bus.ex_pred_target = ppc;
  endtask

  task automatic idle();
    ex(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic push(input logic cr, input logic pcsel, input logic mis, input logic [31:0] rd,
                      input logic cp, input logic pt, input logic [31:0] pg);
    exp_t e;
    e.chk_res  = cr;
    e.pcsel    = pcsel;
    e.mis      = mis;
    e.redir    = rd;
    e.chk_pred = cp;
    e.pt       = pt;
    e.ptgt     = pg;
    sb.push_back(e);
  endtask

  task automatic check(input string nm);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: scoreboard empty, got nothing expected one record", nm);
    end else begin
      e = sb.pop_front();
      if (e.chk_res) begin
        cmp({nm, " PCsel"},       32'(bus.PCsel),      32'(e.pcsel));
        cmp({nm, " mispredict"},  32'(bus.mispredict), 32'(e.mis));
        cmp({nm, " redirect_pc"}, bus.redirect_pc,     e.redir);
      end
      if (e.chk_pred) begin
        cmp({nm, " pred_taken"},  32'(bus.pred_taken), 32'(e.pt));
        cmp({nm, " pred_target"}, bus.pred_target,     e.ptgt);
      end
    end
  endtask

  task automatic cnts(input string nm, input int bc, input int mc);
    cmp({nm, " branch_cnt"},  32'(bus.branch_cnt),  32'(bc));
    cmp({nm, " mispred_cnt"}, 32'(bus.mispred_cnt), 32'(mc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{3'b000, 4'b1100};
    tbl[1] = '{3'b001, 4'b0011};
    tbl[2] = '{3'b010, 4'b0000};
    tbl[3] = '{3'b011, 4'b0000};
    tbl[4] = '{3'b100, 4'b1010};
    tbl[5] = '{3'b101, 4'b0101};
    tbl[6] = '{3'b110, 4'b1010};
    tbl[7] = '{3'b111, 4'b0101};

    rst = 1'b1;
    lk(32'h100);
    idle();
    repeat (2) @(posedge clk);
    #1;
    push(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h104);
    check("reset lookup");
    cnts("reset", 0, 0);
    tick();
    rst = 1'b0;

    // funct3 x comparator sweep, prediction always not-taken
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) begin
        cc = 2'(c);
        tick();
        ex(1'b1, 1'b1, 1'b0, tbl[i].func, cc[1], cc[0], 32'h300, 32'h380, 1'b0, 32'h304);
        push(1'b1, tbl[i].mask[cc], tbl[i].mask[cc], tbl[i].mask[cc] ? 32'h380 : 32'h304,
             1'b0, 1'b0, 32'h0);
        check($sformatf("sweep f%0d eq%0d lt%0d", tbl[i].func, cc[1], cc[0]));
      end
    end
    tick();
    idle();
    @(negedge clk);
    cnts("after sweep", 15, 12);

    tick();
    rst = 1'b1;
    lk(32'h300);
    push(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h304);
    check("second reset lookup");
    cnts("second reset", 0, 0);
    tick();
    rst = 1'b0;

    tick(); lk(32'h200); ex(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h200, 32'h180, 1'b0, 32'h204);
    push(1'b1, 1'b1, 1'b1, 32'h180, 1'b1, 1'b0, 32'h204); check("first taken");
    tick(); ex(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h200, 32'h180, 1'b1, 32'h180);
    push(1'b1, 1'b0, 1'b1, 32'h204, 1'b1, 1'b1, 32'h180); check("nt1 same-cycle old entry");
    tick(); ex(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h200, 32'h180, 1'b0, 32'h204);
    push(1'b1, 1'b0, 1'b0, 32'h204, 1'b1, 1'b0, 32'h180); check("nt2 ctr01");
    tick();
    push(1'b1, 1'b0, 1'b0, 32'h204, 1'b1, 1'b0, 32'h180); check("nt3 ctr00");
    tick(); ex(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h200, 32'h180, 1'b0, 32'h204);
    push(1'b1, 1'b1, 1'b1, 32'h180, 1'b1, 1'b0, 32'h180); check("t1 ctr00 sat");
    tick();
    push(1'b1, 1'b1, 1'b1, 32'h180, 1'b1, 1'b0, 32'h180); check("t2 ctr01");
    tick(); ex(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h200, 32'h180, 1'b1, 32'h180);
    push(1'b1, 1'b1, 1'b0, 32'h180, 1'b1, 1'b1, 32'h180); check("t3 ctr10");
    tick();
    push(1'b1, 1'b1, 1'b0, 32'h180, 1'b1, 1'b1, 32'h180); check("t4 ctr11");
    tick(); ex(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h200, 32'h180, 1'b1, 32'h180);
    push(1'b1, 1'b0, 1'b1, 32'h204, 1'b1, 1'b1, 32'h180); check("nt ctr11 sat");
    tick(); idle();
    push(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h180); check("ctr10 after sat");

    tick(); ex(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h240, 32'h400, 1'b0, 32'h244);
    push(1'b1, 1'b1, 1'b1, 32'h400, 1'b1, 1'b1, 32'h180); check("alias alloc");
    tick(); idle();
    push(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h204); check("alias old misses");
    tick(); lk(32'h240);
    push(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400); check("alias new hits");

    tick(); lk(32'h500); ex(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h500, 32'h600, 1'b0, 32'h504);
    push(1'b1, 1'b0, 1'b0, 32'h504, 1'b1, 1'b0, 32'h504); check("gated jump");
    tick(); idle();
    push(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h504); check("gated jump no update");
    tick(); ex(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 32'h500, 32'h600, 1'b0, 32'h504);
    push(1'b1, 1'b1, 1'b1, 32'h600, 1'b1, 1'b0, 32'h504); check("jump");
    tick(); idle();
    push(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600); check("jump alloc ctr11");
    cnts("sequence", 11, 7);

    for (int k = 0; k < 20; k++) begin
      tick(); lk(32'h700); ex(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h700, 32'h800, 1'b0, 32'h704);
      push(1'b1, 1'b1, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0);
      check($sformatf("mispred burst %0d", k));
    end
    tick(); idle();
    @(negedge clk);
    cnts("saturated", 15, 15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction block: the next generation of the control-unit branch decoder. It resolves all six RISC-V conditional branch encodings plus jumps in the execute stage and drives PCsel. It also keeps a direct-mapped branch target buffer (BTB) of 2-bit saturating counters, so fetch can predict taken branches. On a wrong prediction it raises a mispredict/redirect to the PC logic and counts the event in statistics registers.

## Interface
- XLEN, 32: address/data width.
- ENTRIES, 16: BTB depth; power of two, at least 2; IDX_W = log2(ENTRIES).
- CNT_W, 16: width of the statistics counters.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- if_pc  in  XLEN  fetch PC for the lookup.
- pred_taken  out  1  fetch prediction: take pred_target.
- pred_target  out  XLEN  predicted target.
- ex_valid  in  1  execute-stage instruction is valid (not bubble/flushed).
- branchOP  in  1  instruction is a conditional branch.
- jump  in  1  instruction is JAL/JALR.
- func  in  3  funct3 of the branch.
- BrEQ, BrLT  in  1 each  comparator results; BrLT is already signed or unsigned per funct3.
- ex_pc  in  XLEN  PC of the execute instruction.
- ex_target  in  XLEN  computed branch/jump target.
- ex_pred_taken  in  1  prediction issued at fetch, piped to execute.
- ex_pred_target  in  XLEN  predicted target, piped to execute.
- PCsel  out  1  resolved outcome: taken.
- mispredict  out  1  flush younger instructions and redirect fetch.
- redirect_pc  out  XLEN  correct next PC when mispredict = 1.
- branch_cnt, mispred_cnt  out  CNT_W each  statistics.

## Operation
- **Resolution (combinational)**
  - Gated by ex_valid. With ex_valid = 0: PCsel = 0 and mispredict = 0.
  - If jump: taken.
  - Else if branchOP, by func:
    - 000: BrEQ.
    - 001: !BrEQ.
    - 100 and 110: BrLT.
    - 101 and 111: !BrLT.
    - 010 or 011: not taken, treated as not-a-branch (no update, no count).
  - Otherwise not taken.
- **Prediction outputs**
  - mispredict = resolved-branch & (taken != ex_pred_taken | (taken & ex_target != ex_pred_target)).
  - redirect_pc = taken ? ex_target : ex_pc + 4, modulo 2^XLEN.
- **BTB entry fields:** valid, tag = pc[XLEN-1:IDX_W+2], target, ctr[1:0].
- **Index:** pc[IDX_W+1:2].
- **Lookup (combinational on if_pc)**
  - Hit requires valid and a tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = stored target on a hit, else if_pc + 4.
- **Update, at the clock edge, for a resolved branch/jump with ex_valid = 1**
  - Hit: target <= ex_target when taken. Counter moves up on taken, down on not taken, saturating at 00 and 11. A jump forces ctr to 11.
  - Miss and taken: allocate the entry, overwriting unconditionally. Set valid = 1, the tag, target = ex_target, and ctr = 10 (branch) or 11 (jump).
  - Miss and not taken: no change.
- **Statistics**
  - branch_cnt increments per resolved branch/jump.
  - mispred_cnt increments per mispredict.
  - Both saturate at all-ones.

## Timing
- Lookup and resolution have zero latency (same cycle).
- A table update is visible to lookups from the next cycle.
- Same cycle, same index for lookup and update: the lookup returns the pre-update value; no bypass.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits = 0 and all ctr = 01.
  - Both counters = 0.
  - Outputs during reset: pred_taken = 0, pred_target = if_pc + 4; PCsel, mispredict and redirect_pc follow the combinational inputs.
  - The first update is accepted on the first rising edge after rst falls.
- No handshake: one resolution per cycle, and the PC logic must act on mispredict in the same cycle.

## Test plan
- **Reset then lookup:** assert rst, lookup 0x100 -> pred_taken = 0, pred_target = 0x104, both counters 0.
- **Funct3 sweep:** ex_valid = 1, branchOP = 1 with all 8 func values × BrEQ/BrLT combinations -> PCsel matches the resolution list; 010/011 always 0.
- **First taken branch:** taken branch at 0x200, target 0x180, ex_pred_taken = 0 -> mispredict = 1, redirect_pc = 0x180. The next-cycle lookup of 0x200 gives pred_taken = 1, target 0x180.
- **Counter saturation:** repeat the not-taken branch at 0x200 -> ctr 10→01→00 (pred_taken drops after the first update). Three more taken outcomes -> 01→10→11, and the counter stays at 11.
- **Index aliasing:** with ENTRIES = 16, a taken branch at 0x240 (same index as 0x200) -> the entry is replaced, and a lookup of 0x200 misses.
- **Jump, gating and saturation:** ex_valid = 0 with jump = 1 -> PCsel = 0, no update. With CNT_W = 4, drive 20 mispredicts -> mispred_cnt = 15. Same-cycle lookup/update on one index returns the old entry.
